// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: run states, instruction
// field layout and the opcode values the fetch stage and its neighbours agree on.
package fetch_unit_pkg;

   // Run-control states, encoded as seen on state_out.
   typedef enum logic [1:0] {
      FS_LOAD = 2'd0,
      FS_HALT = 2'd1,
      FS_RUN  = 2'd2
   } fetch_state_e;

   // Instruction word layout: {opcode, immediate}.
   localparam int INSN_OP_MSB = 7;
   localparam int INSN_OP_LSB = 4;
   localparam int INSN_IM_MSB = 3;
   localparam int INSN_IM_LSB = 0;

   // Opcodes shared with the decoder.
   localparam logic [3:0] OP_NOP      = 4'h0;
   localparam logic [3:0] OP_ADD_A_IM = 4'h1;
   localparam logic [3:0] OP_MOV_B_A  = 4'h2;
   localparam logic [3:0] OP_MOV_A_IM = 4'h3;
   localparam logic [3:0] OP_MOV_A_B  = 4'h4;
   localparam logic [3:0] OP_ADD_B_IM = 4'h5;
   localparam logic [3:0] OP_IN_A     = 4'h6;
   localparam logic [3:0] OP_MOV_B_IM = 4'h7;
   localparam logic [3:0] OP_IN_B     = 4'h8;
   localparam logic [3:0] OP_OUT_B    = 4'h9;
   localparam logic [3:0] OP_OUT_IM   = 4'hB;
   localparam logic [3:0] OP_JNC_IM   = 4'hE;
   localparam logic [3:0] OP_JMP_IM   = 4'hF;

   // Opcode field of an 8-bit instruction word.
   function automatic logic [3:0] insn_op(input logic [7:0] word);
      return word[INSN_OP_MSB:INSN_OP_LSB];
   endfunction

   // Immediate field of an 8-bit instruction word.
   function automatic logic [3:0] insn_im(input logic [7:0] word);
      return word[INSN_IM_MSB:INSN_IM_LSB];
   endfunction

endpackage

// File: rtl/fetch_rom.sv
// Program store for the fetch stage: a small register array with a synchronous
// write port for download and an asynchronous read port addressed by the PC.
// Reset wipes the whole store back to NOPs so a partial download never survives.
module fetch_rom
   import fetch_unit_pkg::*;
#(
   parameter int PC_WIDTH   = 4,
   parameter int INSN_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  n_reset,
   input  logic                  wr_en_i,
   input  logic [PC_WIDTH-1:0]   wr_addr_i,
   input  logic [INSN_WIDTH-1:0] wr_data_i,
   input  logic [PC_WIDTH-1:0]   rd_addr_i,
   output logic [INSN_WIDTH-1:0] rd_data_o
);

   localparam int DEPTH = 2 ** PC_WIDTH;
   localparam logic [INSN_WIDTH-1:0] NOP_WORD = {OP_NOP, {(INSN_WIDTH - 4){1'b0}}};

   logic [INSN_WIDTH-1:0] mem_q [DEPTH];

   // Store array: cleared to NOPs on reset, one word written per accepted download beat.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= NOP_WORD;
         end
      end else if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and sequencing stage. Owns the program store, the PC, the
// carry flag and the LOAD/HALT/RUN run-control machine. The word at PC is
// presented combinationally to the decoder; exec_en tells every architectural
// register whether this cycle counts as an executed instruction.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int PC_WIDTH   = 4,
   parameter int INSN_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  n_reset,
   input  logic                  prog_valid,
   output logic                  prog_ready,
   input  logic [PC_WIDTH-1:0]   prog_addr,
   input  logic [INSN_WIDTH-1:0] prog_data,
   input  logic                  prog_start,
   input  logic                  prog_done,
   input  logic                  run_en,
   input  logic                  halt_req,
   input  logic                  step,
   input  logic                  pc_load,
   input  logic                  carry_in,
   output logic [3:0]            op_out,
   output logic [3:0]            imm_out,
   output logic                  carry_out,
   output logic [PC_WIDTH-1:0]   pc_out,
   output logic                  exec_en,
   output logic [1:0]            state_out
);

   fetch_state_e          state_q;
   fetch_state_e          state_d;
   logic [PC_WIDTH-1:0]   pc_q;
   logic [PC_WIDTH-1:0]   pc_d;
   logic                  carry_q;
   logic                  carry_d;
   logic [INSN_WIDTH-1:0] rom_word_s;
   logic                  rom_we_s;
   logic                  clear_s;
   logic                  exec_s;
   logic                  ready_s;
   logic [PC_WIDTH-1:0]   jump_target_s;

   fetch_rom #(
      .PC_WIDTH   (PC_WIDTH),
      .INSN_WIDTH (INSN_WIDTH)
   ) u_rom (
      .clk       (clk),
      .n_reset   (n_reset),
      .wr_en_i   (rom_we_s),
      .wr_addr_i (prog_addr),
      .wr_data_i (prog_data),
      .rd_addr_i (pc_q),
      .rd_data_o (rom_word_s)
   );

   // Run-control next state, download gating and the execute qualifier.
   always_comb begin
      state_d  = state_q;
      exec_s   = 1'b0;
      ready_s  = 1'b0;
      rom_we_s = 1'b0;
      clear_s  = 1'b0;
      case (state_q)
         FS_LOAD: begin
            // Downloads are accepted every cycle here, including the one carrying prog_done.
            ready_s  = 1'b1;
            rom_we_s = prog_valid;
            if (prog_done) begin
               state_d = FS_HALT;
            end else begin
               state_d = FS_LOAD;
            end
         end
         FS_HALT: begin
            // A step executes in place even if the machine is about to start running.
            exec_s = step & ~prog_start;
            if (prog_start) begin
               state_d = FS_LOAD;
               clear_s = 1'b1;
            end else if (run_en && !halt_req) begin
               state_d = FS_RUN;
            end else begin
               state_d = FS_HALT;
            end
         end
         FS_RUN: begin
            // The instruction in flight always completes, even on the cycle we stop.
            exec_s = 1'b1;
            if (halt_req || !run_en) begin
               state_d = FS_HALT;
            end else begin
               state_d = FS_RUN;
            end
         end
         default: begin
            // An unreachable encoding falls back to a clean LOAD.
            state_d = FS_LOAD;
            clear_s = 1'b1;
         end
      endcase
   end

   assign jump_target_s = PC_WIDTH'(imm_out);

   // PC and carry update: cleared on entry to LOAD, advanced only on executed cycles.
   always_comb begin
      pc_d    = pc_q;
      carry_d = carry_q;
      if (clear_s) begin
         pc_d    = {PC_WIDTH{1'b0}};
         carry_d = 1'b0;
      end else if (exec_s) begin
         // Increment wraps naturally at the top of the store.
         if (pc_load) begin
            pc_d = jump_target_s;
         end else begin
            pc_d = pc_q + PC_WIDTH'(1);
         end
         carry_d = carry_in;
      end else begin
         pc_d    = pc_q;
         carry_d = carry_q;
      end
   end

   // Architectural state registers of the fetch stage.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= FS_LOAD;
         pc_q    <= {PC_WIDTH{1'b0}};
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         carry_q <= carry_d;
      end
   end

   assign op_out     = rom_word_s[INSN_OP_MSB:INSN_OP_LSB];
   assign imm_out    = rom_word_s[INSN_IM_MSB:INSN_IM_LSB];
   assign carry_out  = carry_q;
   assign pc_out     = pc_q;
   assign exec_en    = exec_s;
   assign prog_ready = ready_s;
   assign state_out  = state_q;

endmodule
